// File: rtl/message_reply_tx_pkg.sv
// Command codes shared with the message interpreter, reply classification
// and the state encodings used by the reply transmitter.
package message_reply_tx_pkg;

  localparam logic [7:0] CMD_WAYPOINT_FIRST = 8'd1;
  localparam logic [7:0] CMD_WAYPOINT_LAST  = 8'd8;
  localparam logic [7:0] CMD_STOP           = 8'd9;
  localparam logic [7:0] CMD_BEGIN          = 8'd10;
  localparam logic [7:0] CMD_X              = 8'd20;
  localparam logic [7:0] CMD_Y              = 8'd21;
  localparam logic [7:0] CMD_THETA          = 8'd22;
  localparam logic [7:0] CMD_RPM0           = 8'd30;
  localparam logic [7:0] CMD_RPM1           = 8'd31;
  localparam logic [7:0] CMD_RPM2           = 8'd32;
  localparam logic [7:0] CMD_RPM3           = 8'd33;
  localparam logic [7:0] CMD_DIST0          = 8'd40;
  localparam logic [7:0] CMD_DIST1          = 8'd41;
  localparam logic [7:0] CMD_DIST2          = 8'd42;
  localparam logic [7:0] CMD_DIST3          = 8'd43;
  localparam logic [7:0] CMD_BEHAVIOR       = 8'd50;
  localparam logic [7:0] CMD_IMU0           = 8'd60;
  localparam logic [7:0] CMD_IMU1           = 8'd61;
  localparam logic [7:0] CMD_IMU2           = 8'd62;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_ACK  = 2'd1,
    CLS_DATA = 2'd2
  } cmd_class_e;

  typedef enum logic [1:0] {
    CTL_IDLE = 2'd0,
    CTL_WAIT = 2'd1,
    CTL_SEND = 2'd2
  } ctl_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Motion commands are acknowledged by echo; telemetry queries return data.
  function automatic cmd_class_e classify_cmd(input logic [7:0] c);
    cmd_class_e r;
    r = CLS_NONE;
    if (c inside {[CMD_WAYPOINT_FIRST:CMD_WAYPOINT_LAST], CMD_STOP, CMD_BEGIN})
      r = CLS_ACK;
    else if (c inside {CMD_X, CMD_Y, CMD_THETA,
                       CMD_RPM0, CMD_RPM1, CMD_RPM2, CMD_RPM3,
                       CMD_DIST0, CMD_DIST1, CMD_DIST2, CMD_DIST3,
                       CMD_BEHAVIOR, CMD_IMU0, CMD_IMU1, CMD_IMU2})
      r = CLS_DATA;
    return r;
  endfunction

endpackage

// File: rtl/message_reply_tx_if.sv
// Command/reply bundle between the interpreter side and the reply transmitter.
interface message_reply_tx_if #(parameter int INT_WIDTH = 8);

  logic                 MESSAGE_REPLY_FLAGDATAIN_In;
  logic [INT_WIDTH-1:0] MESSAGE_REPLY_CMD_InBus;
  logic [INT_WIDTH-1:0] MESSAGE_REPLY_DATA_InBus;
  logic                 MESSAGE_REPLY_TX_Out;
  logic                 MESSAGE_REPLY_BUSY_Out;
  logic                 MESSAGE_REPLY_DONE_Out;
  logic                 MESSAGE_REPLY_OVERRUN_Out;

  modport master (
    output MESSAGE_REPLY_FLAGDATAIN_In, MESSAGE_REPLY_CMD_InBus, MESSAGE_REPLY_DATA_InBus,
    input  MESSAGE_REPLY_TX_Out, MESSAGE_REPLY_BUSY_Out, MESSAGE_REPLY_DONE_Out,
           MESSAGE_REPLY_OVERRUN_Out
  );

  modport slave (
    input  MESSAGE_REPLY_FLAGDATAIN_In, MESSAGE_REPLY_CMD_InBus, MESSAGE_REPLY_DATA_InBus,
    output MESSAGE_REPLY_TX_Out, MESSAGE_REPLY_BUSY_Out, MESSAGE_REPLY_DONE_Out,
           MESSAGE_REPLY_OVERRUN_Out
  );

endinterface

// File: rtl/message_reply_tx_uart_tx_core.sv
// 8N1 serialiser: i_load starts a frame, o_last flags the final stop-bit cycle,
// o_done pulses on return to idle. TX is a registered copy of the next state.
module message_reply_tx_uart_tx_core
  import message_reply_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int INT_WIDTH    = 8
) (
  input  logic                 MESSAGE_INTERPRETER_CLOCK_50,
  input  logic                 MESSAGE_INTERPRETER_RESET_InHigh,
  input  logic                 i_load,
  input  logic [INT_WIDTH-1:0] i_load_dat,
  output logic                 o_tx,
  output logic                 o_done,
  output logic                 o_last
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(INT_WIDTH);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(INT_WIDTH - 1);

  tx_state_e            r_state, w_state_nxt;
  logic [BW-1:0]        r_baud, w_baud_nxt;
  logic [IW-1:0]        r_bit, w_bit_nxt;
  logic [INT_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_baud_end;

  assign w_baud_end = (r_baud == BAUD_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;
    o_last      = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (i_load) begin
          w_state_nxt = TX_START;
          w_shift_nxt = i_load_dat;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end
      end
      TX_START: begin
        w_baud_nxt = w_baud_end ? '0 : r_baud + BW'(1);
        if (w_baud_end) w_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        w_baud_nxt = w_baud_end ? '0 : r_baud + BW'(1);
        if (w_baud_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == BIT_LAST) w_state_nxt = TX_STOP;
          else                   w_bit_nxt   = r_bit + IW'(1);
        end
      end
      TX_STOP: begin
        w_baud_nxt = w_baud_end ? '0 : r_baud + BW'(1);
        if (w_baud_end) begin
          w_state_nxt = TX_IDLE;
          w_done_nxt  = 1'b1;
          o_last      = 1'b1;
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
    // Line level follows the state being entered so TX changes with the state.
    case (w_state_nxt)
      TX_START: w_tx_nxt = 1'b0;
      TX_DATA:  w_tx_nxt = w_shift_nxt[0];
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge MESSAGE_INTERPRETER_CLOCK_50 or posedge MESSAGE_INTERPRETER_RESET_InHigh) begin
    if (MESSAGE_INTERPRETER_RESET_InHigh) begin
      r_state <= TX_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_tx   = r_tx;
  assign o_done = r_done;

endmodule

// File: rtl/message_reply_tx.sv
// Sends the interpreter's reply byte on UART TX after each accepted command flag edge:
// ACK codes echo the command, DATA codes send DATA_InBus captured LATCH_DELAY cycles later.
module message_reply_tx
  import message_reply_tx_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int LATCH_DELAY  = 2,
  parameter int INT_WIDTH    = 8
) (
  input  logic                MESSAGE_INTERPRETER_CLOCK_50,
  input  logic                MESSAGE_INTERPRETER_RESET_InHigh,
  message_reply_tx_if.slave   bus
);

  localparam logic [2:0] DELAY_INIT = 3'(LATCH_DELAY - 1);

  ctl_state_e           r_ctl, w_ctl_nxt;
  logic [2:0]           r_delay, w_delay_nxt;
  logic                 r_flag_d;
  logic                 r_busy;
  logic                 r_overrun;
  logic                 w_edge;
  logic                 w_overrun_nxt;
  cmd_class_e           w_class;
  logic                 w_load;
  logic [INT_WIDTH-1:0] w_load_dat;
  logic                 w_tx, w_done, w_last;

  assign w_edge  = bus.MESSAGE_REPLY_FLAGDATAIN_In & ~r_flag_d;
  assign w_class = classify_cmd(bus.MESSAGE_REPLY_CMD_InBus);

  // Triggers are only accepted in IDLE; a valid one anywhere else is an overrun.
  assign w_overrun_nxt = w_edge && (w_class != CLS_NONE) && (r_ctl != CTL_IDLE);

  always_comb begin
    w_ctl_nxt   = r_ctl;
    w_delay_nxt = r_delay;
    w_load      = 1'b0;
    w_load_dat  = bus.MESSAGE_REPLY_CMD_InBus;
    case (r_ctl)
      CTL_IDLE: begin
        if (w_edge && w_class == CLS_ACK) begin
          w_load    = 1'b1;
          w_ctl_nxt = CTL_SEND;
        end else if (w_edge && w_class == CLS_DATA) begin
          w_ctl_nxt   = CTL_WAIT;
          w_delay_nxt = DELAY_INIT;
        end
      end
      CTL_WAIT: begin
        if (r_delay == 3'd0) begin
          w_load     = 1'b1;
          w_load_dat = bus.MESSAGE_REPLY_DATA_InBus;
          w_ctl_nxt  = CTL_SEND;
        end else begin
          w_delay_nxt = r_delay - 3'd1;
        end
      end
      CTL_SEND: begin
        if (w_last) w_ctl_nxt = CTL_IDLE;
      end
      default: w_ctl_nxt = CTL_IDLE;
    endcase
  end

  always_ff @(posedge MESSAGE_INTERPRETER_CLOCK_50 or posedge MESSAGE_INTERPRETER_RESET_InHigh) begin
    if (MESSAGE_INTERPRETER_RESET_InHigh) begin
      r_ctl     <= CTL_IDLE;
      r_delay   <= '0;
      r_flag_d  <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_ctl     <= w_ctl_nxt;
      r_delay   <= w_delay_nxt;
      r_flag_d  <= bus.MESSAGE_REPLY_FLAGDATAIN_In;
      r_busy    <= (w_ctl_nxt != CTL_IDLE);
      r_overrun <= w_overrun_nxt;
    end
  end

  message_reply_tx_uart_tx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .INT_WIDTH    (INT_WIDTH)
  ) u_tx_core (
    .MESSAGE_INTERPRETER_CLOCK_50     (MESSAGE_INTERPRETER_CLOCK_50),
    .MESSAGE_INTERPRETER_RESET_InHigh (MESSAGE_INTERPRETER_RESET_InHigh),
    .i_load                           (w_load),
    .i_load_dat                       (w_load_dat),
    .o_tx                             (w_tx),
    .o_done                           (w_done),
    .o_last                           (w_last)
  );

  assign bus.MESSAGE_REPLY_TX_Out      = w_tx;
  assign bus.MESSAGE_REPLY_BUSY_Out    = r_busy;
  assign bus.MESSAGE_REPLY_DONE_Out    = w_done;
  assign bus.MESSAGE_REPLY_OVERRUN_Out = r_overrun;

endmodule

// File: tb/tb_message_reply_tx.sv
// Directed and randomized checks of message_reply_tx against a frame-level reference model.
module tb_message_reply_tx;

  localparam int CPB = 4;
  localparam int LD  = 2;

  logic clk;
  logic rst;
  int   n_asrt;
  int   n_fail;

  message_reply_tx_if #(.INT_WIDTH(8)) bus ();

  message_reply_tx #(
    .CLKS_PER_BIT (CPB),
    .LATCH_DELAY  (LD),
    .INT_WIDTH    (8)
  ) dut (
    .MESSAGE_INTERPRETER_CLOCK_50     (clk),
    .MESSAGE_INTERPRETER_RESET_InHigh (rst),
    .bus                              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 = ignored, 1 = acknowledge by echo, 2 = reply with data byte
  function automatic int model_class(input int c);
    int data_codes[$] = '{20, 21, 22, 30, 31, 32, 33, 40, 41, 42, 43, 50, 60, 61, 62};
    if (c >= 1 && c <= 10) return 1;
    foreach (data_codes[i]) if (data_codes[i] == c) return 2;
    return 0;
  endfunction

  // Line level of an 8N1 frame during bit slot s (0 = start, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] pay, input int s);
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return logic'((pay >> (s - 1)) & 8'd1);
  endfunction

  task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] d_trig,
                         input logic [7:0] d_cap, input logic [7:0] d_late,
                         input bit hold, input int inject_k, input int idle_n,
                         input string tag);
    int         cls;
    logic [7:0] pay;
    int         ovr_cnt;
    bit         busy_bad;
    cls     = model_class(int'(cmd));
    pay     = (cls == 1) ? cmd : d_cap;
    ovr_cnt = 0;
    busy_bad = 1'b0;
    @(posedge clk); #1;
    bus.MESSAGE_REPLY_CMD_InBus     = cmd;
    bus.MESSAGE_REPLY_DATA_InBus    = d_trig;
    bus.MESSAGE_REPLY_FLAGDATAIN_In = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus.MESSAGE_REPLY_FLAGDATAIN_In = 1'b0;
    bus.MESSAGE_REPLY_DATA_InBus = d_cap;
    @(negedge clk);
    if (cls == 0) begin
      for (int i = 0; i < idle_n; i++) begin
        if (bus.MESSAGE_REPLY_BUSY_Out !== 1'b0 || bus.MESSAGE_REPLY_TX_Out !== 1'b1) busy_bad = 1'b1;
        ovr_cnt += int'(bus.MESSAGE_REPLY_OVERRUN_Out);
        @(negedge clk);
      end
      chk({tag, " ignored: busy/tx idle"}, 32'(busy_bad), 32'd0);
      chk({tag, " ignored: overrun"}, 32'(ovr_cnt), 32'd0);
      bus.MESSAGE_REPLY_FLAGDATAIN_In = 1'b0;
      return;
    end
    chk({tag, " busy after trigger"}, 32'(bus.MESSAGE_REPLY_BUSY_Out), 32'd1);
    if (cls == 2) repeat (LD) @(negedge clk);
    bus.MESSAGE_REPLY_DATA_InBus = d_late;
    for (int k = 0; k < 10 * CPB; k++) begin
      chk({tag, " tx line"}, 32'(bus.MESSAGE_REPLY_TX_Out), 32'(frame_bit(pay, k / CPB)));
      if (bus.MESSAGE_REPLY_BUSY_Out !== 1'b1 || bus.MESSAGE_REPLY_DONE_Out !== 1'b0) busy_bad = 1'b1;
      ovr_cnt += int'(bus.MESSAGE_REPLY_OVERRUN_Out);
      if (k == inject_k) begin
        bus.MESSAGE_REPLY_CMD_InBus     = 8'd5;
        bus.MESSAGE_REPLY_FLAGDATAIN_In = 1'b1;
      end
      if (k == inject_k + 1) bus.MESSAGE_REPLY_FLAGDATAIN_In = 1'b0;
      @(negedge clk);
    end
    chk({tag, " busy/done during frame"}, 32'(busy_bad), 32'd0);
    chk({tag, " done at frame end"}, 32'(bus.MESSAGE_REPLY_DONE_Out), 32'd1);
    chk({tag, " busy at frame end"}, 32'(bus.MESSAGE_REPLY_BUSY_Out), 32'd0);
    chk({tag, " tx at frame end"}, 32'(bus.MESSAGE_REPLY_TX_Out), 32'd1);
    busy_bad = 1'b0;
    for (int i = 0; i < idle_n; i++) begin
      @(negedge clk);
      if (bus.MESSAGE_REPLY_BUSY_Out !== 1'b0 || bus.MESSAGE_REPLY_TX_Out !== 1'b1 ||
          bus.MESSAGE_REPLY_DONE_Out !== 1'b0) busy_bad = 1'b1;
      ovr_cnt += int'(bus.MESSAGE_REPLY_OVERRUN_Out);
    end
    chk({tag, " quiet after frame"}, 32'(busy_bad), 32'd0);
    chk({tag, " overrun pulses"}, 32'(ovr_cnt), (inject_k >= 0) ? 32'd1 : 32'd0);
    bus.MESSAGE_REPLY_FLAGDATAIN_In = 1'b0;
  endtask

  initial begin
    logic [7:0] rc, rd;
    bit         idle_bad;
    n_asrt = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.MESSAGE_REPLY_FLAGDATAIN_In = 1'b0;
    bus.MESSAGE_REPLY_CMD_InBus     = 8'd0;
    bus.MESSAGE_REPLY_DATA_InBus    = 8'd0;
    #1;
    chk("reset tx", 32'(bus.MESSAGE_REPLY_TX_Out), 32'd1);
    chk("reset busy", 32'(bus.MESSAGE_REPLY_BUSY_Out), 32'd0);
    chk("reset done", 32'(bus.MESSAGE_REPLY_DONE_Out), 32'd0);
    chk("reset overrun", 32'(bus.MESSAGE_REPLY_OVERRUN_Out), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    idle_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.MESSAGE_REPLY_TX_Out !== 1'b1 || bus.MESSAGE_REPLY_BUSY_Out !== 1'b0 ||
          bus.MESSAGE_REPLY_DONE_Out !== 1'b0) idle_bad = 1'b1;
    end
    chk("idle after reset", 32'(idle_bad), 32'd0);

    run_cmd(8'd9, 8'h00, 8'h00, 8'h00, 1'b0, -1, 10, "ack stop");
    run_cmd(8'd30, 8'h00, 8'hA5, 8'hFF, 1'b0, -1, 10, "rpm latch");
    run_cmd(8'd20, 8'h3C, 8'h3C, 8'h3C, 1'b1, -1, 160, "held flag");
    run_cmd(8'd42, 8'h00, 8'h96, 8'h69, 1'b0, 15, 20, "overrun");
    run_cmd(8'd15, 8'h00, 8'h55, 8'h55, 1'b0, -1, 60, "undefined");

    // Reset in the middle of a frame must drop the line and busy at once.
    @(posedge clk); #1;
    bus.MESSAGE_REPLY_CMD_InBus     = 8'd2;
    bus.MESSAGE_REPLY_FLAGDATAIN_In = 1'b1;
    @(posedge clk); #1;
    bus.MESSAGE_REPLY_FLAGDATAIN_In = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midframe reset tx", 32'(bus.MESSAGE_REPLY_TX_Out), 32'd1);
    chk("midframe reset busy", 32'(bus.MESSAGE_REPLY_BUSY_Out), 32'd0);
    chk("midframe reset done", 32'(bus.MESSAGE_REPLY_DONE_Out), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_cmd(8'd2, 8'h00, 8'h00, 8'h00, 1'b0, -1, 10, "after reset");

    for (int n = 0; n < 8; n++) begin
      rc = 8'($urandom_range(0, 70));
      rd = 8'($urandom);
      run_cmd(rc, 8'($urandom), rd, 8'($urandom), 1'b0, -1, 12, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/message_reply_tx.md
Name: message_reply_tx

Overview:
- Downstream neighbour of the message interpreter: sends the interpreter's reply byte back to the host over the UART TX line.
- Watches the same command flag and byte the interpreter receives.
- Waits for the interpreter's registered data output to settle, then serialises one 8N1 frame.
- Telemetry queries get the requested data byte; motion commands get their command code echoed back as an acknowledge.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (434), clock cycles per UART bit; minimum legal value is 4.
- LATCH_DELAY, 2, cycles from flag rising edge to capture of MESSAGE_REPLY_DATA_InBus; range 1..7.
- INT_WIDTH, 8, byte width.

Ports:
- MESSAGE_INTERPRETER_CLOCK_50  in  1  50 MHz system clock
- MESSAGE_INTERPRETER_RESET_InHigh  in  1  asynchronous reset, active-high
- MESSAGE_REPLY_FLAGDATAIN_In  in  1  command-byte-valid flag from UART RX, level or pulse, active-high
- MESSAGE_REPLY_CMD_InBus  in  8  received command byte (same bus the interpreter decodes)
- MESSAGE_REPLY_DATA_InBus  in  8  interpreter data output (reply payload)
- MESSAGE_REPLY_TX_Out  out  1  UART serial line, idle high
- MESSAGE_REPLY_BUSY_Out  out  1  high from accepted trigger until end of stop bit
- MESSAGE_REPLY_DONE_Out  out  1  one-cycle pulse after stop bit completes
- MESSAGE_REPLY_OVERRUN_Out  out  1  one-cycle pulse when a trigger is dropped because BUSY is high

Behaviour:
- Reset is asynchronous and active-high. While in reset:
  - TX_Out=1, BUSY=0, DONE=0, OVERRUN=0.
  - FSM=IDLE; all counters and the shift register are cleared.
  - The flag edge-detector history register is cleared.
- Reset asserted mid-frame aborts the frame immediately; TX returns high with no partial stop bit.
- Trigger: a rising edge of FLAGDATAIN, registered one cycle. A held-high flag gives one trigger only.
- Classification of the command byte, sampled on the trigger cycle:
  - Codes 1..10 are ACK class: the payload is the command byte itself.
  - Codes 20..22, 30..33, 40..43, 50, 60..62 are DATA class: the payload is DATA_InBus captured later.
  - All other codes are ignored: no frame and no OVERRUN.
- FSM:
  - IDLE:
    - Trigger with a valid class: BUSY goes to 1 on the next cycle.
    - DATA class goes to WAIT with the delay counter = LATCH_DELAY-1.
    - ACK class loads the shift register with the command byte and goes to START.
  - WAIT: decrements each cycle. At 0, captures DATA_InBus into the shift register and goes to START.
    - Capture occurs exactly LATCH_DELAY cycles after the cycle the edge was detected.
  - START: TX=0 for CLKS_PER_BIT cycles, then goes to DATA with bit index 0.
  - DATA: TX = shift[0], LSB first, for CLKS_PER_BIT cycles per bit. The register shifts right after each bit. After bit 7 the FSM goes to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles. It then goes to IDLE, BUSY drops, and DONE pulses for 1 cycle in the same cycle as the IDLE entry.
- Frame length is exactly 10*CLKS_PER_BIT cycles from START entry to IDLE entry.
- A trigger in any non-IDLE state, including the IDLE-entry cycle with BUSY still high, is dropped. OVERRUN pulses 1 cycle and the frame in flight is not disturbed.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is clog2(CLKS_PER_BIT).
- Captured payload is held stable through the whole frame; changes on DATA_InBus after capture have no effect.
- All outputs are registered; TX is glitch-free.

Decomposition:
- Shared package/include holds the command-code constants (waypoint 1..8, stop 9, begin 10, x/y/theta 20..22, rpm 30..33, dist 40..43, behavior 50, imu 60..62).
  - The interpreter and this block both use it.
- Shared package also holds the FSM state encoding localparams.
- One natural sub-module: uart_tx_core, covering the baud counter, shift register and START/DATA/STOP sequencing with a load/busy/done handshake.
  - message_reply_tx keeps the edge detect, classification, WAIT delay and overrun logic.

Test Plan:
- Reset with CLKS_PER_BIT=4, then idle 100 cycles -> TX=1, BUSY=0, DONE=0 throughout.
- Flag pulse with CMD=9 (stop) -> ACK frame 0x09: TX sequence 0,1,0,0,1,0,0,0,0,1 with each bit 4 cycles; DONE pulses at cycle 40 after START entry.
- CMD=30 with DATA_InBus changing 0x00 to 0xA5 one cycle after the edge, then to 0xFF after capture (LATCH_DELAY=2) -> frame carries 0xA5, LSB first 1,0,1,0,0,1,0,1.
- Flag held high for 200 cycles with CMD=20 -> exactly one frame and no OVERRUN.
- Second flag edge (CMD=5) during the DATA state of a frame -> OVERRUN pulses once, the first frame completes intact, no second frame follows.
- CMD=15 (undefined) -> no frame, BUSY stays 0. Reset asserted mid-DATA of a CMD=2 frame -> TX=1 and BUSY=0 within the same cycle; next trigger after reset sends a clean frame.
